// File: rtl/jtkcpu_mdu_pkg.sv
// jtkcpu_mdu_pkg: shared definitions for the KCPU multiply/divide unit.
// Holds the MDU op encodings, the FSM state encoding and small op decoders.
package jtkcpu_mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULU = 2'd0,
    MDU_MULS = 2'd1,
    MDU_DIVU = 2'd2,
    MDU_DIVS = 2'd3
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == MDU_DIVU) || (op == MDU_DIVS);
  endfunction

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == MDU_MULS) || (op == MDU_DIVS);
  endfunction

endpackage

// File: rtl/jtkcpu_mdu_step.sv
// jtkcpu_mdu_step: combinational single-bit iteration of the MDU.
//   is_div_i : 0 = shift-add multiply step, 1 = restoring divide step
//   hi_i/lo_i: accumulator pair (mul: partial product / multiplier,
//              div: partial remainder / dividend-then-quotient)
//   b_i      : multiplicand magnitude or divisor magnitude
//   hi_o/lo_o: accumulator pair after one step
module jtkcpu_mdu_step #(
  parameter int unsigned W = 16
) (
  input  logic         is_div_i,
  input  logic [W-1:0] hi_i,
  input  logic [W-1:0] lo_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  logic [W:0]   mul_sum;
  logic [W:0]   div_sh;
  logic [W-1:0] div_diff;
  logic         div_ge;

  // Multiply: add multiplicand when the current multiplier bit is set, then shift right
  assign mul_sum = {1'b0, hi_i} + {1'b0, (lo_i[0] ? b_i : '0)};

  // Divide: shift next dividend bit into the remainder and try subtracting the divisor;
  // the remainder stays below the divisor, so the difference always fits in W bits
  assign div_sh   = {hi_i, lo_i[W-1]};
  assign div_ge   = div_sh >= {1'b0, b_i};
  assign div_diff = W'(div_sh - {1'b0, b_i});

  always_comb begin
    if (is_div_i) begin
      hi_o = div_ge ? div_diff : div_sh[W-1:0];
      lo_o = {lo_i[W-2:0], div_ge};
    end else begin
      hi_o = mul_sum[W:1];
      lo_o = {mul_sum[0], lo_i[W-1:1]};
    end
  end

endmodule

// File: rtl/jtkcpu_mdu.sv
// jtkcpu_mdu: iterative signed/unsigned multiply/divide unit for the KCPU.
//   clk, rst (sync, active-high), cen (clock enable for all state)
//   start/op/op0/op1 : request, latched when idle on a cen edge
//   busy, done       : handshake; done is a one-cen-cycle pulse
//   rslt_lo/rslt_hi  : product low/high, or quotient/remainder
//   c, v, z, n       : condition flags
// Build option: define JTKCPU_MDU_RADIX4_EN to retire 2 bits per cen cycle
// (latency W/2+2 instead of W+2); results are identical in both builds.
module jtkcpu_mdu
  import jtkcpu_mdu_pkg::*;
#(
  parameter int unsigned W    = 16,
  parameter int unsigned CNTW = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cen,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] op0,
  input  logic [W-1:0] op1,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] rslt_lo,
  output logic [W-1:0] rslt_hi,
  output logic         c,
  output logic         v,
  output logic         z,
  output logic         n
);

`ifdef JTKCPU_MDU_RADIX4_EN
  localparam int unsigned STEPS = 2;
`else
  localparam int unsigned STEPS = 1;
`endif
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(W / STEPS);
  localparam logic [W-1:0]    MIN_NEG  = {1'b1, {(W-1){1'b0}}};

  mdu_state_e    state_q, state_d;
  mdu_op_e       op_q, op_d;
  logic [W-1:0]  b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic          qs_q, qs_d, rs_q, rs_d, ovf_q, ovf_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [W-1:0]  rlo_q, rlo_d, rhi_q, rhi_d;
  logic          c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;

  logic          is_div, is_signed;
  logic [W-1:0]  abs0, abs1, run_hi, run_lo, s1_hi, s1_lo;
  logic [W-1:0]  quot_fix, rem_fix;
  logic [2*W-1:0] prod_fix;

  assign is_div    = op_is_div(op_q);
  assign is_signed = op_is_signed(op_q);

  // Operand magnitudes (latched op0 sits in lo_q, op1 in b_q during PREP)
  assign abs0 = (is_signed && lo_q[W-1]) ? -lo_q : lo_q;
  assign abs1 = (is_signed && b_q[W-1])  ? -b_q  : b_q;

  // Sign correction of the magnitude results
  assign prod_fix = qs_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quot_fix = qs_q ? -lo_q : lo_q;
  assign rem_fix  = rs_q ? -hi_q : hi_q;

  jtkcpu_mdu_step #(.W(W)) u_step1 (
    .is_div_i (is_div),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .b_i      (b_q),
    .hi_o     (s1_hi),
    .lo_o     (s1_lo)
  );

`ifdef JTKCPU_MDU_RADIX4_EN
  logic [W-1:0] s2_hi, s2_lo;
  logic [W+1:0] b3_q, b3_d, r4_add, r4_sum;

  jtkcpu_mdu_step #(.W(W)) u_step2 (
    .is_div_i (is_div),
    .hi_i     (s1_hi),
    .lo_i     (s1_lo),
    .b_i      (b_q),
    .hi_o     (s2_hi),
    .lo_o     (s2_lo)
  );

  // Radix-4 multiply: add 0/1x/2x/3x of the multiplicand, then shift by two
  always_comb begin
    unique case (lo_q[1:0])
      2'd0:    r4_add = '0;
      2'd1:    r4_add = {2'b00, b_q};
      2'd2:    r4_add = {1'b0, b_q, 1'b0};
      default: r4_add = b3_q;
    endcase
  end
  assign r4_sum = {2'b00, hi_q} + r4_add;
  assign run_hi = is_div ? s2_hi : r4_sum[W+1:2];
  assign run_lo = is_div ? s2_lo : {r4_sum[1:0], lo_q[W-1:2]};
`else
  assign run_hi = s1_hi;
  assign run_lo = s1_lo;
`endif

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    qs_d    = qs_q;
    rs_d    = rs_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rlo_d   = rlo_q;
    rhi_d   = rhi_q;
    c_d     = c_q;
    v_d     = v_q;
    z_d     = z_q;
    n_d     = n_q;
`ifdef JTKCPU_MDU_RADIX4_EN
    b3_d    = b3_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = mdu_op_e'(op);
          lo_d    = op0;
          b_d     = op1;
          busy_d  = 1'b1;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        qs_d    = is_signed & (lo_q[W-1] ^ b_q[W-1]);
        rs_d    = is_signed & is_div & lo_q[W-1];
        ovf_d   = 1'b0;
        hi_d    = '0;
        lo_d    = abs0;
        b_d     = abs1;
        cnt_d   = CNT_LOAD;
        state_d = ST_RUN;
`ifdef JTKCPU_MDU_RADIX4_EN
        b3_d    = {2'b00, abs1} + {1'b0, abs1, 1'b0};
`endif
        // Special divides skip RUN with final values already in place
        if (is_div && (b_q == '0)) begin
          qs_d    = 1'b0;
          rs_d    = 1'b0;
          ovf_d   = 1'b1;
          lo_d    = '1;
          hi_d    = lo_q;
          state_d = ST_FIX;
        end else if (is_div && is_signed && (lo_q == MIN_NEG) && (b_q == '1)) begin
          qs_d    = 1'b0;
          rs_d    = 1'b0;
          ovf_d   = 1'b1;
          lo_d    = MIN_NEG;
          hi_d    = '0;
          state_d = ST_FIX;
        end
      end
      ST_RUN: begin
        hi_d  = run_hi;
        lo_d  = run_lo;
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (is_div) begin
          rlo_d = quot_fix;
          rhi_d = rem_fix;
          c_d   = 1'b0;
          v_d   = ovf_q;
          z_d   = (quot_fix == '0);
          n_d   = quot_fix[W-1];
        end else begin
          rlo_d = prod_fix[W-1:0];
          rhi_d = prod_fix[2*W-1:W];
          c_d   = prod_fix[2*W-1];
          v_d   = 1'b0;
          z_d   = (prod_fix == '0);
          n_d   = prod_fix[2*W-1];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset overrides cen
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= MDU_MULU;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      qs_q    <= 1'b0;
      rs_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rlo_q   <= '0;
      rhi_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
`ifdef JTKCPU_MDU_RADIX4_EN
      b3_q    <= '0;
`endif
    end else if (cen) begin
      state_q <= state_d;
      op_q    <= op_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      qs_q    <= qs_d;
      rs_q    <= rs_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rlo_q   <= rlo_d;
      rhi_q   <= rhi_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
      n_q     <= n_d;
`ifdef JTKCPU_MDU_RADIX4_EN
      b3_q    <= b3_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rslt_lo = rlo_q;
  assign rslt_hi = rhi_q;
  assign c       = c_q;
  assign v       = v_q;
  assign z       = z_q;
  assign n       = n_q;

endmodule

// File: tb/tb_jtkcpu_mdu.sv
// tb_jtkcpu_mdu: scoreboard bench for jtkcpu_mdu (W=16). The driver pushes
// the expected result of every accepted request; a monitor pops and compares
// on each done pulse, including the latency in cen cycles.
module tb_jtkcpu_mdu;

  localparam int unsigned W = 16;
`ifdef JTKCPU_MDU_RADIX4_EN
  localparam int unsigned LAT = W / 2 + 2;
`else
  localparam int unsigned LAT = W + 2;
`endif
  localparam int unsigned BUDGET = 400;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, lo, hi;
    logic         c, v, z, n;
    int unsigned  done_at;
    int unsigned  lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cen = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] op0 = '0, op1 = '0;
  logic         busy, done, c, v, z, n;
  logic [W-1:0] rslt_lo, rslt_hi;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cen_edges = 0;
  bit          cen_toggle = 1'b0;
  exp_t        sb_q[$];

  jtkcpu_mdu #(.W(W)) dut (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .op(op),
    .op0(op0), .op1(op1), .busy(busy), .done(done),
    .rslt_lo(rslt_lo), .rslt_hi(rslt_hi), .c(c), .v(v), .z(z), .n(n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cen) cen_edges <= cen_edges + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sb, p, q, r;
    logic [2*W-1:0] prod;
    e.op = o; e.a = a; e.b = b; e.c = 1'b0; e.v = 1'b0; e.lat = LAT; e.done_at = 0;
    if (o[0]) begin sa = longint'($signed(a)); sb = longint'($signed(b)); end
    else begin sa = longint'(a); sb = longint'(b); end
    if (!o[1]) begin
      p = sa * sb;
      prod = p[2*W-1:0];
      e.lo = prod[W-1:0]; e.hi = prod[2*W-1:W];
      e.c = prod[2*W-1]; e.n = prod[2*W-1]; e.z = (prod == '0);
    end else begin
      if (b == '0) begin
        e.lo = '1; e.hi = a; e.v = 1'b1; e.lat = 2;
      end else if (o[0] && a == 16'h8000 && b == 16'hFFFF) begin
        e.lo = 16'h8000; e.hi = '0; e.v = 1'b1; e.lat = 2;
      end else begin
        q = sa / sb; r = sa % sb;
        e.lo = q[W-1:0]; e.hi = r[W-1:0];
      end
      e.z = (e.lo == '0); e.n = e.lo[W-1];
    end
    return e;
  endfunction

  task automatic step_clk();
    @(posedge clk);
    #1;
    cen = cen_toggle ? ~cen : 1'b1;
  endtask

  task automatic wait_idle();
    int unsigned k = 0;
    while (busy !== 1'b0) begin
      step_clk();
      if (++k > BUDGET) begin
        chk("wait_idle_timeout", 32'(busy), 32'd0);
        return;
      end
    end
  endtask

  // Issue one request, hold start until a cen edge accepts it, then score it
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    bit   acc;
    wait_idle();
    op = o; op0 = a; op1 = b; start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      acc = cen;
      step_clk();
      if (acc) break;
    end
    start = 1'b0;
    e = model(o, a, b);
    e.done_at = cen_edges + e.lat;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    int unsigned k = 0;
    while (sb_q.size() != 0) begin
      step_clk();
      if (++k > BUDGET) begin
        chk("drain_timeout", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        return;
      end
    end
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h0001;
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: compares every done pulse seen on a cen edge against the scoreboard
  initial begin
    exp_t e;
    bit   ce, rs;
    forever begin
      @(posedge clk);
      ce = cen; rs = rst;
      #2;
      if (!rs && ce && done === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("lo op=%0d a=%h b=%h", e.op, e.a, e.b), 32'(rslt_lo), 32'(e.lo));
          chk($sformatf("hi op=%0d a=%h b=%h", e.op, e.a, e.b), 32'(rslt_hi), 32'(e.hi));
          chk($sformatf("cvzn op=%0d a=%h b=%h", e.op, e.a, e.b),
              32'({c, v, z, n}), 32'({e.c, e.v, e.z, e.n}));
          chk($sformatf("latency op=%0d a=%h b=%h", e.op, e.a, e.b), cen_edges, e.done_at);
          chk("busy_at_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  initial begin
    int unsigned e_acc;
    // Reset state
    repeat (3) step_clk();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_lo", 32'(rslt_lo), 32'd0);
    chk("rst_hi", 32'(rslt_hi), 32'd0);
    chk("rst_flags", 32'({c, v, z, n}), 32'd0);
    rst = 1'b0;
    step_clk();

    // Directed cases
    issue(2'd0, 16'hFFFF, 16'hFFFF);
    issue(2'd1, 16'hFFFF, 16'h0002);
    issue(2'd1, 16'h0000, 16'h1234);
    issue(2'd3, 16'hFFF9, 16'h0002);
    issue(2'd2, 16'h0007, 16'h0002);
    issue(2'd2, 16'h1234, 16'h0000);
    issue(2'd3, 16'h8000, 16'hFFFF);
    issue(2'd3, 16'h8000, 16'h0001);
    issue(2'd3, 16'h0007, 16'hFFFE);
    drain();

    // cen toggling, with a second start while busy that must be dropped
    cen_toggle = 1'b1;
    issue(2'd0, 16'h0003, 16'h0005);
    repeat (4) step_clk();
    op = 2'd2; op0 = 16'h0055; op1 = 16'h0000; start = 1'b1;
    repeat (3) step_clk();
    start = 1'b0;
    drain();
    cen_toggle = 1'b0;
    step_clk();

    // Randomised traffic, some with cen toggling
    for (int i = 0; i < 150; i++) begin
      cen_toggle = ($urandom_range(0, 3) == 0);
      issue(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand());
    end
    drain();
    cen_toggle = 1'b0;
    step_clk();

    // Abort in RUN: reset clears everything, no done follows
    issue(2'd0, 16'h1357, 16'h2468);
    e_acc = sb_q[0].done_at - LAT;
    sb_q.delete();
    while (cen_edges < e_acc + 5) step_clk();
    rst = 1'b1;
    step_clk();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_lo", 32'(rslt_lo), 32'd0);
    chk("abort_hi", 32'(rslt_hi), 32'd0);
    chk("abort_flags", 32'({c, v, z, n}), 32'd0);
    rst = 1'b0;
    repeat (LAT + 4) step_clk();
    chk("abort_still_idle", 32'(busy), 32'd0);
    issue(2'd1, 16'hFF00, 16'h0100);
    drain();
    repeat (3) step_clk();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
